// File: rtl/vid_timing_pkg.sv
// Shared types, helpers and standard timing presets for the video timing generator.
package vid_timing_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOP_PEND = 2'd2
  } state_t;

  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] v_active;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
    logic        hs_pol;
    logic        vs_pol;
  } timing_t;

  function automatic int unsigned axis_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  localparam timing_t TIMING_1080P60 = '{
    h_active: 16'd1920, h_fp: 16'd88,  h_sync: 16'd44, h_bp: 16'd148,
    v_active: 16'd1080, v_fp: 16'd4,   v_sync: 16'd5,  v_bp: 16'd36,
    hs_pol: 1'b1, vs_pol: 1'b1
  };

  localparam timing_t TIMING_720P60 = '{
    h_active: 16'd1280, h_fp: 16'd110, h_sync: 16'd40, h_bp: 16'd220,
    v_active: 16'd720,  v_fp: 16'd5,   v_sync: 16'd5,  v_bp: 16'd20,
    hs_pol: 1'b1, vs_pol: 1'b1
  };

  // 640x480 uses negative sync polarity on both axes.
  localparam timing_t TIMING_480P = '{
    h_active: 16'd640,  h_fp: 16'd16,  h_sync: 16'd96, h_bp: 16'd48,
    v_active: 16'd480,  v_fp: 16'd10,  v_sync: 16'd2,  v_bp: 16'd33,
    hs_pol: 1'b0, vs_pol: 1'b0
  };

endpackage

// File: rtl/vtg_axis_cnt.sv
// One raster axis: a wrap counter with active, sync and last-position decode flags.
module vtg_axis_cnt
  import vid_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = 8,
  parameter int unsigned FP     = 2,
  parameter int unsigned SYNC   = 2,
  parameter int unsigned BP     = 2,
  parameter int unsigned CW     = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          step,
  output logic [CW-1:0] cnt,
  output logic          active,
  output logic          sync,
  output logic          last
);

  localparam int unsigned   TOTAL    = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CW-1:0] ACT_END  = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_BEG = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_END = CW'(ACTIVE + FP + SYNC);
  localparam logic [CW-1:0] LAST_VAL = CW'(TOTAL - 1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end

  assign active = (cnt < ACT_END);
  assign sync   = (cnt >= SYNC_BEG) && (cnt < SYNC_END);
  assign last   = (cnt == LAST_VAL);

endmodule

// File: rtl/vid_timing_gen.sv
// Video raster timing generator: HS/VS/DE plus frame-start pulse, started and
// stopped only on frame boundaries under a level enable.
module vid_timing_gen
  import vid_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1920,
  parameter int unsigned H_FP     = 88,
  parameter int unsigned H_SYNC   = 44,
  parameter int unsigned H_BP     = 148,
  parameter int unsigned V_ACTIVE = 1080,
  parameter int unsigned V_FP     = 4,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 36,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter int unsigned CW       = 12
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  output logic          hs_o,
  output logic          vs_o,
  output logic          de_o,
  output logic          fs_o,
  output logic [CW-1:0] x_o,
  output logic [CW-1:0] y_o,
  output logic          busy_o,
  output logic [15:0]   frame_cnt_o
);

  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);

  state_t        state;
  state_t        state_next;
  logic          run;
  logic [CW-1:0] hcnt;
  logic [CW-1:0] vcnt;
  logic          h_active;
  logic          h_sync;
  logic          h_last;
  logic          v_active;
  logic          v_sync;
  logic          v_last;
  logic          frame_last;

  assign run        = (state != IDLE);
  assign frame_last = h_last && v_last;

  vtg_axis_cnt #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)
  ) u_h_axis (
    .clk   (clk_i),
    .rst   (rst_i),
    .clr   (!run),
    .step  (run),
    .cnt   (hcnt),
    .active(h_active),
    .sync  (h_sync),
    .last  (h_last)
  );

  vtg_axis_cnt #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)
  ) u_v_axis (
    .clk   (clk_i),
    .rst   (rst_i),
    .clr   (!run),
    .step  (run && h_last),
    .cnt   (vcnt),
    .active(v_active),
    .sync  (v_sync),
    .last  (v_last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Dropping en_i on the very last frame cycle stops right there instead of
  // detouring through STOP_PEND for a whole extra frame.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (en_i) state_next = RUN;
      end
      RUN: begin
        if (!en_i) state_next = frame_last ? IDLE : STOP_PEND;
      end
      STOP_PEND: begin
        if (en_i)            state_next = RUN;
        else if (frame_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hs_o        <= ~HS_POL;
      vs_o        <= ~VS_POL;
      de_o        <= 1'b0;
      fs_o        <= 1'b0;
      x_o         <= '0;
      y_o         <= '0;
      busy_o      <= 1'b0;
      frame_cnt_o <= 16'd0;
    end else begin
      hs_o   <= (run && h_sync) ? HS_POL : ~HS_POL;
      vs_o   <= (run && v_sync) ? VS_POL : ~VS_POL;
      de_o   <= run && h_active && v_active;
      fs_o   <= run && (vcnt == VS_FIRST) && (hcnt == '0);
      x_o    <= hcnt;
      y_o    <= vcnt;
      busy_o <= run;
      if (run && frame_last) begin
        frame_cnt_o <= frame_cnt_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_vid_timing_gen.sv
// Scoreboard bench for vid_timing_gen on a 14x7 raster, both sync polarities.
module tb_vid_timing_gen;

  localparam int CW    = 4;
  localparam int H_TOT = 14;
  localparam int V_TOT = 7;
  localparam int F_TOT = H_TOT * V_TOT;

  typedef struct packed {
    logic        busy;
    logic        fs;
    logic        de;
    logic        vs;
    logic        hs;
    logic [3:0]  x;
    logic [3:0]  y;
    logic [15:0] fcnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          en_i = 1'b0;
  logic          hs_p, vs_p, de_p, fs_p, busy_p;
  logic          hs_n, vs_n, de_n, fs_n, busy_n;
  logic [CW-1:0] x_p, y_p, x_n, y_n;
  logic [15:0]   fcnt_p, fcnt_n;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  bit          m_active = 1'b0;
  int          m_pos = 0;
  logic [15:0] m_fcnt = 16'd0;

  int   t_de, t_hs, t_hs_rise, t_vs, t_fs, t_busy, t_hsn_low, t_fs_gap;
  int   mon_cyc, last_fs;
  logic prev_hs;

  always #5 clk = ~clk;

  vid_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW)
  ) dut_p (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i),
    .hs_o(hs_p), .vs_o(vs_p), .de_o(de_p), .fs_o(fs_p),
    .x_o(x_p), .y_o(y_p), .busy_o(busy_p), .frame_cnt_o(fcnt_p)
  );

  vid_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW)
  ) dut_n (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i),
    .hs_o(hs_n), .vs_o(vs_n), .de_o(de_n), .fs_o(fs_n),
    .x_o(x_n), .y_o(y_n), .busy_o(busy_n), .frame_cnt_o(fcnt_n)
  );

  task automatic check_output(input string name, input logic [63:0] act,
                              input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
    end
  endtask

  // Reference raster as a flat frame position: line = pos / 14, column = pos % 14.
  function automatic exp_t decode(input int pos);
    exp_t e;
    int   h;
    int   v;
    h      = pos % H_TOT;
    v      = pos / H_TOT;
    e      = '0;
    e.de   = (h < 8) && (v < 4);
    e.hs   = (h >= 10) && (h < 12);
    e.vs   = (v == 5);
    e.fs   = (v == 5) && (h == 0);
    e.x    = 4'(h);
    e.y    = 4'(v);
    e.busy = 1'b1;
    return e;
  endfunction

  // One clock per count; the model stops only when en is low on a frame's final cycle.
  task automatic apply_stimulus(input logic en, input logic rst, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      en_i  = en;
      rst_i = rst;
      if (rst) begin
        e = '0;
      end else if (!m_active) begin
        e      = '0;
        e.fcnt = m_fcnt;
      end else begin
        e      = decode(m_pos);
        e.fcnt = (m_pos == F_TOT - 1) ? m_fcnt + 16'd1 : m_fcnt;
      end
      if (rst) begin
        m_active = 1'b0;
        m_pos    = 0;
        m_fcnt   = 16'd0;
      end else if (!m_active) begin
        m_active = en;
        m_pos    = 0;
      end else if (m_pos == F_TOT - 1) begin
        m_fcnt   = m_fcnt + 16'd1;
        m_active = en;
        m_pos    = 0;
      end else begin
        m_pos = m_pos + 1;
      end
      @(posedge clk);
      #1;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_tally();
    t_de = 0; t_hs = 0; t_hs_rise = 0; t_vs = 0; t_fs = 0;
    t_busy = 0; t_hsn_low = 0; t_fs_gap = 0; mon_cyc = 0; last_fs = -1;
  endtask

  initial begin
    exp_t e;
    exp_t en_e;
    prev_hs = 1'b0;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e         = exp_q.pop_front();
        en_e      = e;
        en_e.hs   = ~e.hs;
        en_e.vs   = ~e.vs;
        check_output("raster_pos_pol",
                     {busy_p, fs_p, de_p, vs_p, hs_p, x_p, y_p, fcnt_p}, 64'(e));
        check_output("raster_neg_pol",
                     {busy_n, fs_n, de_n, vs_n, hs_n, x_n, y_n, fcnt_n}, 64'(en_e));
        t_de      += int'(de_p);
        t_hs      += int'(hs_p);
        t_hs_rise += int'(hs_p && !prev_hs);
        t_vs      += int'(vs_p);
        t_busy    += int'(busy_p);
        t_hsn_low += int'(!hs_n);
        if (fs_p) begin
          t_fs++;
          if (last_fs >= 0) t_fs_gap = mon_cyc - last_fs;
          last_fs = mon_cyc;
        end
        prev_hs = hs_p;
        mon_cyc++;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clear_tally();
    apply_stimulus(1'b0, 1'b1, 3);
    apply_stimulus(1'b0, 1'b0, 3);

    // Three back-to-back frames; en drops exactly on the last cycle of the third.
    drain();
    clear_tally();
    apply_stimulus(1'b1, 1'b0, 3 * F_TOT);
    apply_stimulus(1'b0, 1'b0, 6);
    drain();
    check_output("s1_de_cycles", 64'(t_de), 64'd96);
    check_output("s1_hs_cycles", 64'(t_hs), 64'd42);
    check_output("s1_hs_pulses", 64'(t_hs_rise), 64'd21);
    check_output("s1_vs_cycles", 64'(t_vs), 64'd42);
    check_output("s1_fs_pulses", 64'(t_fs), 64'd3);
    check_output("s1_fs_spacing", 64'(t_fs_gap), 64'd98);
    check_output("s1_busy_cycles", 64'(t_busy), 64'd294);
    check_output("s1_hs_neg_low", 64'(t_hsn_low), 64'd42);
    check_output("s1_frame_cnt", 64'(fcnt_p), 64'd3);

    // Stop request at frame cycle 40: the frame still completes.
    clear_tally();
    apply_stimulus(1'b1, 1'b0, 41);
    apply_stimulus(1'b0, 1'b0, 65);
    drain();
    check_output("s2_busy_cycles", 64'(t_busy), 64'd98);
    check_output("s2_de_cycles", 64'(t_de), 64'd32);
    check_output("s2_fs_pulses", 64'(t_fs), 64'd1);
    check_output("s2_frame_cnt", 64'(fcnt_p), 64'd4);
    check_output("s2_idle_levels", {61'd0, busy_p, hs_p, hs_n}, 64'b001);

    // Stop request withdrawn at cycle 60: raster continues without a gap.
    clear_tally();
    apply_stimulus(1'b1, 1'b0, 41);
    apply_stimulus(1'b0, 1'b0, 20);
    apply_stimulus(1'b1, 1'b0, 135);
    apply_stimulus(1'b0, 1'b0, 8);
    drain();
    check_output("s3_busy_cycles", 64'(t_busy), 64'd196);
    check_output("s3_fs_pulses", 64'(t_fs), 64'd2);
    check_output("s3_fs_spacing", 64'(t_fs_gap), 64'd98);
    check_output("s3_de_cycles", 64'(t_de), 64'd64);
    check_output("s3_frame_cnt", 64'(fcnt_p), 64'd6);

    // Reset pulse mid-frame with en held high.
    clear_tally();
    apply_stimulus(1'b1, 1'b0, 50);
    apply_stimulus(1'b1, 1'b1, 1);
    check_output("s4_reset_outs", {44'd0, busy_p, de_p, fs_p, hs_p, vs_p, hs_n, vs_n, x_p, y_p, fcnt_p == 16'd0},
                 {44'd0, 7'b0000011, 4'd0, 4'd0, 1'b1});
    apply_stimulus(1'b1, 1'b0, 1);
    check_output("s4_de_after_1clk", 64'(de_p), 64'd0);
    apply_stimulus(1'b1, 1'b0, 1);
    check_output("s4_first_pixel", {55'd0, de_p, x_p, y_p}, {55'd0, 1'b1, 4'd0, 4'd0});
    apply_stimulus(1'b1, 1'b0, 96);
    apply_stimulus(1'b0, 1'b0, 5);
    drain();
    check_output("s4_frame_cnt", 64'(fcnt_p), 64'd1);
    check_output("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
